mem_access_unit: RTL and testbench

Data-memory access stage of the 5-stage RISC-V pipeline, and the producer of the `mem_data` word consumed by the write-back mux. It takes a load/store from the EX/MEM register and runs a req/gnt/rvalid transaction on the data-memory bus. It aligns store data into byte lanes and extracts and sign- or zero-extends load data. While a transaction is in flight it holds the pipeline with `stall`.

---
 rtl/riscv_lsu_pkg.sv | 20 ++
 rtl/lsu_align.sv | 95 +++++++++
 rtl/mem_access_unit.sv | 133 +++++++++++++
 tb/tb_mem_access_unit.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_lsu_pkg.sv
// Shared definitions for the data-memory access stage: RV32I load/store
// funct3 encodings and the access-FSM state encoding.
package riscv_lsu_pkg;

  // RV32I load/store size and sign encodings (funct3)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Access FSM state type and encodings
  typedef logic [1:0] lsu_state_t;

  localparam lsu_state_t ST_IDLE = 2'd0;
  localparam lsu_state_t ST_REQ  = 2'd1;
  localparam lsu_state_t ST_WAIT = 2'd2;
  localparam lsu_state_t ST_DONE = 2'd3;

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic for the data-memory access stage:
// legality/alignment check, store byte enables and lane replication,
// and load-data extraction with sign/zero extension.
module lsu_align
  import riscv_lsu_pkg::*;
(
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        access_err,
  output logic [31:0] load_data
);

  logic        legal_f3;
  logic        misaligned;
  logic [3:0]  store_be;
  logic [31:0] rdata_shift;

  // Legality of funct3 for the operation actually performed, plus alignment.
  // A load wins when both mem_read and mem_write are set.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    legal_f3   = 1'b0;
    misaligned = 1'b0;
    if (mem_read) begin
      case (funct3)
        F3_B, F3_BU: legal_f3 = 1'b1;
        F3_H, F3_HU: begin
          legal_f3   = 1'b1;
          misaligned = addr_lo[0];
        end
        F3_W: begin
          legal_f3   = 1'b1;
          misaligned = |addr_lo;
        end
        default: legal_f3 = 1'b0;
      endcase
    end else begin
      case (funct3)
        F3_B: legal_f3 = 1'b1;
        F3_H: begin
          legal_f3   = 1'b1;
          misaligned = addr_lo[0];
        end
        F3_W: begin
          legal_f3   = 1'b1;
          misaligned = |addr_lo;
        end
        default: legal_f3 = 1'b0;
      endcase
    end
    access_err = (mem_read | mem_write) & (~legal_f3 | misaligned);
  end

  // Store lane steering: enables shifted to the addressed lane, data
  // replicated across all lanes so the memory picks the enabled one.
  always_comb begin
    store_be = 4'b1111;
    wdata    = store_data;
    case (funct3)
      F3_B: begin
        store_be = 4'b0001 << addr_lo;
        wdata    = {4{store_data[7:0]}};
      end
      F3_H: begin
        store_be = 4'b0011 << addr_lo;
        wdata    = {2{store_data[15:0]}};
      end
      default: begin
        store_be = 4'b1111;
        wdata    = store_data;
      end
    endcase
    be = mem_read ? 4'b1111 : store_be;
  end

  // Load extract: move the addressed lane down to bit 0, then extend.
  always_comb begin
    rdata_shift = rdata >> {addr_lo, 3'b000};
    case (funct3)
      F3_B:    load_data = {{24{rdata_shift[7]}}, rdata_shift[7:0]};
      F3_H:    load_data = {{16{rdata_shift[15]}}, rdata_shift[15:0]};
      F3_BU:   load_data = {24'h0, rdata_shift[7:0]};
      F3_HU:   load_data = {16'h0, rdata_shift[15:0]};
      default: load_data = rdata_shift;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory access stage: runs one req/gnt/rvalid bus transaction per
// load/store, stalls the pipeline while it is in flight, and holds the
// extracted load result for write-back.
module mem_access_unit
  import riscv_lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       store_data,
  output logic [31:0]       mem_data,
  output logic              stall,
  output logic              misalign_err,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [3:0]        dmem_be,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [31:0]       dmem_rdata
);

  lsu_state_t        state_q, state_d;
  logic              dmem_req_q, dmem_req_d;
  logic              dmem_we_q, dmem_we_d;
  logic [3:0]        dmem_be_q, dmem_be_d;
  logic [ADDR_W-1:0] dmem_addr_q, dmem_addr_d;
  logic [31:0]       dmem_wdata_q, dmem_wdata_d;
  logic [31:0]       mem_data_q, mem_data_d;

  logic        op_valid;
  logic        access_err;
  logic        start;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [31:0] load_data;

  lsu_align u_align (
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .funct3     (funct3),
    .addr_lo    (addr[1:0]),
    .store_data (store_data),
    .rdata      (dmem_rdata),
    .be         (be_c),
    .wdata      (wdata_c),
    .access_err (access_err),
    .load_data  (load_data)
  );

  assign op_valid = mem_read | mem_write;
  assign start    = (state_q == ST_IDLE) & op_valid & ~access_err;

  // The stall must rise in the accepting IDLE cycle itself, so it is
  // combinational; DONE releases the pipeline.
  assign stall        = start | (state_q == ST_REQ) | (state_q == ST_WAIT);
  assign misalign_err = (state_q == ST_IDLE) & op_valid & access_err;

  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_be    = dmem_be_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign mem_data   = mem_data_q;

  // Next-state and next-register values for the access FSM
  always_comb begin
    state_d      = state_q;
    dmem_req_d   = dmem_req_q;
    dmem_we_d    = dmem_we_q;
    dmem_be_d    = dmem_be_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    mem_data_d   = mem_data_q;
    case (state_q)
      ST_IDLE: begin
        // Bus outputs are captured once here and stay frozen through REQ.
        if (start) begin
          state_d      = ST_REQ;
          dmem_req_d   = 1'b1;
          dmem_we_d    = mem_write & ~mem_read;
          dmem_be_d    = be_c;
          dmem_addr_d  = {addr[ADDR_W-1:2], 2'b00};
          dmem_wdata_d = wdata_c;
        end
      end
      ST_REQ: begin
        if (dmem_gnt) begin
          dmem_req_d = 1'b0;
          state_d    = dmem_we_q ? ST_DONE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (dmem_rvalid) begin
          mem_data_d = load_data;
          state_d    = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and bus/result registers
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments here so every flop samples the values
    // from before the edge, independent of statement order.
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_be_q    <= 4'b0000;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= 32'h0;
      mem_data_q   <= 32'h0;
    end else begin
      state_q      <= state_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_be_q    <= dmem_be_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      mem_data_q   <= mem_data_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases from the design
// notes followed by randomized loads/stores against a behavioural model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data;
  logic [31:0] mem_data;
  logic        stall, misalign_err;
  logic        dmem_req, dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_mem;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .funct3       (funct3),
    .addr         (addr),
    .store_data   (store_data),
    .mem_data     (mem_data),
    .stall        (stall),
    .misalign_err (misalign_err),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_be      (dmem_be),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_gnt     (dmem_gnt),
    .dmem_rvalid  (dmem_rvalid),
    .dmem_rdata   (dmem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  function automatic int acc_bytes(input logic [2:0] f3);
    case (f3[1:0])
      2'd0:    return 1;
      2'd1:    return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit op_legal(input bit rd, input bit wr, input logic [2:0] f3,
                                  input logic [31:0] a);
    int n   = acc_bytes(f3);
    int off = int'(a[1:0]);
    if (!rd && !wr) return 1'b0;
    if (rd) begin
      if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
    end else if (f3 > 3'd2) begin
      return 1'b0;
    end
    return (off % n) == 0;
  endfunction

  function automatic logic [3:0] model_be(input bit rd, input logic [2:0] f3,
                                          input logic [31:0] a);
    int n   = acc_bytes(f3);
    int off = int'(a[1:0]);
    if (rd) return 4'hF;
    return 4'(((1 << n) - 1) << off);
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] sd);
    logic [31:0] b = {24'h0, sd[7:0]};
    logic [31:0] h = {16'h0, sd[15:0]};
    case (acc_bytes(f3))
      1:       return b * 32'h0101_0101;
      2:       return h * 32'h0001_0001;
      default: return sd;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rdat);
    int          n = acc_bytes(f3);
    logic [31:0] v = rdat >> (8 * int'(a[1:0]));
    if (n == 4) return rdat;
    v = v & ((32'd1 << (8 * n)) - 32'd1);
    if (!f3[2] && v[8*n-1]) v = v - (32'd1 << (8 * n));
    return v;
  endfunction

  // ---------------- one pipeline op with a bus responder ----------------
  // gw: REQ cycles without gnt before gnt; rw: extra cycles after the
  // earliest legal rvalid cycle.
  task automatic do_op(input bit rd, input bit wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd,
                       input logic [31:0] rdat, input int gw, input int rw);
    bit legal      = op_legal(rd, wr, f3, a);
    int stalls     = 0;
    int req_cycles = 0;
    int since_gnt  = 0;
    int exp_stalls;
    bit granted    = 1'b0;
    bit done       = 1'b0;
    @(negedge clk);
    mem_read   = rd;
    mem_write  = wr;
    funct3     = f3;
    addr       = a;
    store_data = sd;
    dmem_gnt   = 1'b0;
    dmem_rvalid = 1'b0;
    #1;
    check("misalign_err", 32'(misalign_err), 32'(!legal));
    if (!legal) begin
      check("err_no_stall", 32'(stall), 32'd0);
      @(negedge clk);
      mem_read  = 1'b0;
      mem_write = 1'b0;
      #1;
      check("err_one_cycle", 32'(misalign_err), 32'd0);
      check("err_no_req", 32'(dmem_req), 32'd0);
      check("err_mem_data", mem_data, exp_mem);
      return;
    end
    check("start_stall", 32'(stall), 32'd1);
    stalls = 1;
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      @(negedge clk);
      dmem_gnt    = 1'b0;
      dmem_rvalid = 1'b0;
      dmem_rdata  = $urandom;
      if (dmem_req) begin
        check("req_addr", dmem_addr, {a[31:2], 2'b00});
        check("req_be", 32'(dmem_be), 32'(model_be(rd, f3, a)));
        check("req_we", 32'(dmem_we), 32'(wr && !rd));
        if (!rd) check("req_wdata", dmem_wdata, model_wdata(f3, sd));
        if (req_cycles == gw) begin
          dmem_gnt = 1'b1;
          granted  = 1'b1;
        end else begin
          dmem_rvalid = 1'($urandom);   // must be ignored before gnt
        end
        req_cycles++;
      end else if (granted && rd) begin
        since_gnt++;
        if (since_gnt == rw + 1) begin
          dmem_rvalid = 1'b1;
          dmem_rdata  = rdat;
        end
      end
      #1;
      if (stall) stalls++;
      else done = 1'b1;
    end
    exp_stalls = 1 + (gw + 1) + (rd ? (rw + 1) : 0);
    if (rd) exp_mem = model_load(f3, a, rdat);
    check("completed", 32'(done), 32'd1);
    check("req_cycles", 32'(req_cycles), 32'(gw + 1));
    check("stall_cycles", 32'(stalls), 32'(exp_stalls));
    check("mem_data", mem_data, exp_mem);
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  // Reset asserted while a load waits for rvalid, then a late rvalid.
  task automatic reset_in_wait();
    @(negedge clk);
    mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h40; store_data = '0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    @(negedge clk);               // REQ: grant immediately
    check("rst_req_up", 32'(dmem_req), 32'd1);
    dmem_gnt = 1'b1;
    @(negedge clk);               // WAIT
    dmem_gnt = 1'b0;
    #1;
    check("rst_in_wait_stall", 32'(stall), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_drops_req", 32'(dmem_req), 32'd0);
    check("rst_clears_mem", mem_data, 32'd0);
    exp_mem = 32'd0;
    mem_read = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h8765_4321;
    @(negedge clk);
    dmem_rvalid = 1'b0;
    #1;
    check("late_rvalid_mem", mem_data, 32'd0);
    check("late_rvalid_stall", 32'(stall), 32'd0);
    check("late_rvalid_req", 32'(dmem_req), 32'd0);
  endtask

  initial begin
    rst_n = 1'b1;
    mem_read = 1'b0; mem_write = 1'b0; funct3 = '0; addr = '0; store_data = '0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    exp_mem = 32'd0;
    #3 rst_n = 1'b0;
    @(negedge clk);
    #1;
    check("rst_mem_data", mem_data, 32'd0);
    check("rst_req", 32'(dmem_req), 32'd0);
    check("rst_we", 32'(dmem_we), 32'd0);
    check("rst_be", 32'(dmem_be), 32'd0);
    check("rst_addr", dmem_addr, 32'd0);
    check("rst_wdata", dmem_wdata, 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_err", 32'(misalign_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    do_op(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 32'h0, 0, 0);   // SW
    do_op(1'b0, 1'b1, 3'b000, 32'h103, 32'h0000_00A5, 32'h0, 0, 0);   // SB
    do_op(1'b1, 1'b0, 3'b000, 32'h102, 32'h0, 32'h12F0_4455, 0, 0);   // LB
    check("lb_value", mem_data, 32'hFFFF_FFF0);
    do_op(1'b1, 1'b0, 3'b100, 32'h102, 32'h0, 32'h12F0_4455, 0, 0);   // LBU
    check("lbu_value", mem_data, 32'h0000_00F0);
    do_op(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 32'h12F0_4455, 0, 0);   // LH
    check("lh_value", mem_data, 32'h0000_12F0);
    do_op(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 32'hCAFE_F00D, 2, 1);   // LW, slow bus
    check("lw_value", mem_data, 32'hCAFE_F00D);
    do_op(1'b1, 1'b0, 3'b001, 32'h101, 32'h0, 32'h0, 0, 0);           // LH misaligned
    do_op(1'b1, 1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 0);           // illegal funct3
    check("illegal_keeps_mem", mem_data, 32'hCAFE_F00D);
    do_op(1'b1, 1'b1, 3'b101, 32'h306, 32'h1111_1111, 32'h9ABC_0000, 1, 0); // LHU wins over store
    reset_in_wait();

    // Randomized ops against the model
    for (int i = 0; i < 60; i++) begin
      bit          rd = 1'($urandom);
      bit          wr = 1'($urandom);
      logic [2:0]  f3 = 3'($urandom_range(0, 7));
      if (!rd && !wr) wr = 1'b1;
      do_op(rd, wr, f3, $urandom, $urandom, $urandom,
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
